// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the read-channel FSM encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

endpackage : axi_lite_pkg

// File: rtl/axi_lite_addr_decode.sv
// Combinational AXI4-Lite address decoder: byte address -> register index,
// range flag and one-hot register select. Shared by the read and write slaves.
module axi_lite_addr_decode
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_REGS   = 12,
    localparam int ADDR_LSB  = $clog2(DATA_WIDTH / 8),
    localparam int IDX_W     = ADDR_WIDTH - ADDR_LSB
) (
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  in_range_o,
    output logic [NUM_REGS-1:0]   sel_o
);

    // One extra bit lets NUM_REGS == 2**IDX_W be represented in the unsigned compare.
    localparam logic [IDX_W:0] NUM_REGS_W = (IDX_W + 1)'(NUM_REGS);

    logic [IDX_W:0] idxWide;

    // Drop the byte-lane bits so misaligned addresses alias to their word, then range check.
    always_comb begin
        idx_o      = araddr_i[ADDR_WIDTH-1:ADDR_LSB];
        idxWide    = {1'b0, idx_o};
        in_range_o = (idxWide < NUM_REGS_W);
    end

    // One-hot select of the addressed register; all zero when the index is out of range.
    always_comb begin
        sel_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            sel_o[i] = in_range_o && (idx_o == IDX_W'(i));
        end
    end

endmodule : axi_lite_addr_decode

// File: rtl/axi_lite_reg_read_slave.sv
// AXI4-Lite read-channel slave over a flat bank of status registers.
// Registered read data, SLVERR for unmapped indices, and one-cycle read
// strobes for clear-on-read registers aligned with the first rvalid cycle.
module axi_lite_reg_read_slave
    import axi_lite_pkg::*;
#(
    parameter int                    C_S_AXI_DATA_WIDTH = 32,
    parameter int                    C_S_AXI_ADDR_WIDTH = 6,
    parameter int                    NUM_REGS           = 12,
    parameter logic [NUM_REGS-1:0]   COR_MASK           = '0
) (
    input  logic                                   clk,
    input  logic                                   resetN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic                                   s_axi_arvalid,
    output logic                                   s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                             s_axi_rresp,
    output logic                                   s_axi_rvalid,
    input  logic                                   s_axi_rready,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]                    rd_strobe
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int ADDR_LSB = $clog2(DW / 8);
    localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;

    state_t              state_q,    state_d;
    logic                arReady_q,  arReady_d;
    logic                rValid_q,   rValid_d;
    logic [DW-1:0]       rData_q,    rData_d;
    logic [1:0]          rResp_q,    rResp_d;
    logic [NUM_REGS-1:0] rdStrobe_q, rdStrobe_d;

    logic [IDX_W-1:0]    decIdx;
    logic                decInRange;
    logic [NUM_REGS-1:0] decSel;
    logic [DW-1:0]       readMux;

    axi_lite_addr_decode #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_decode (
        .araddr_i   (s_axi_araddr),
        .idx_o      (decIdx),
        .in_range_o (decInRange),
        .sel_o      (decSel)
    );

    // AND-OR mux over the bank; an out-of-range index selects nothing and yields zero.
    always_comb begin
        readMux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (decSel[i]) begin
                readMux = readMux | reg_in[i*DW +: DW];
            end
        end
    end

    // Next-state and output logic; arready is registered so it stays low until the first edge after reset.
    always_comb begin
        state_d    = state_q;
        arReady_d  = arReady_q;
        rValid_d   = rValid_q;
        rData_d    = rData_q;
        rResp_d    = rResp_q;
        rdStrobe_d = '0;

        unique case (state_q)
            IDLE: begin
                arReady_d = 1'b1;
                rValid_d  = 1'b0;
                if (s_axi_arvalid && arReady_q) begin
                    rData_d    = readMux;
                    rResp_d    = decInRange ? RESP_OKAY : RESP_SLVERR;
                    rdStrobe_d = decSel & COR_MASK;
                    arReady_d  = 1'b0;
                    rValid_d   = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                arReady_d = 1'b0;
                rValid_d  = 1'b1;
                if (s_axi_rready) begin
                    rValid_d  = 1'b0;
                    arReady_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                arReady_d = 1'b0;
                rValid_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any pending response immediately.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            arReady_q  <= 1'b0;
            rValid_q   <= 1'b0;
            rData_q    <= '0;
            rResp_q    <= RESP_OKAY;
            rdStrobe_q <= '0;
        end else begin
            state_q    <= state_d;
            arReady_q  <= arReady_d;
            rValid_q   <= rValid_d;
            rData_q    <= rData_d;
            rResp_q    <= rResp_d;
            rdStrobe_q <= rdStrobe_d;
        end
    end

    assign s_axi_arready = arReady_q;
    assign s_axi_rvalid  = rValid_q;
    assign s_axi_rdata   = rData_q;
    assign s_axi_rresp   = rResp_q;
    assign rd_strobe     = rdStrobe_q;

endmodule : axi_lite_reg_read_slave

// File: tb/tb_axi_lite_reg_read_slave.sv
// Self-checking bench for axi_lite_reg_read_slave (12 x 32-bit registers, register 5 clear-on-read).
module tb_axi_lite_reg_read_slave;

    localparam int          DW    = 32;
    localparam int          AW    = 6;
    localparam int          NREGS = 12;
    localparam logic [11:0] COR   = 12'h020;

    typedef struct {
        logic [DW-1:0]    data;
        logic [1:0]       resp;
        logic [NREGS-1:0] strobe;
    } exp_t;

    logic                clk;
    logic                resetN;
    logic [AW-1:0]       araddr;
    logic                arvalid;
    logic                arready;
    logic [DW-1:0]       rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [NREGS*DW-1:0] regIn;
    logic [NREGS-1:0]    rdStrobe;

    logic [DW-1:0] regs [NREGS];
    exp_t          sb [$];
    int            testCount = 0;
    int            failCount = 0;

    axi_lite_reg_read_slave #(
        .C_S_AXI_DATA_WIDTH (DW),
        .C_S_AXI_ADDR_WIDTH (AW),
        .NUM_REGS           (NREGS),
        .COR_MASK           (COR)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .reg_in        (regIn),
        .rd_strobe     (rdStrobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack the bench's register model into the flat bus.
    always_comb begin
        regIn = '0;
        for (int i = 0; i < NREGS; i++) begin
            regIn[i*DW +: DW] = regs[i];
        end
    end

    // Reference model of what a read of this address must return.
    function automatic exp_t expectFor(input logic [AW-1:0] addr);
        exp_t        e;
        logic [3:0]  idx;
        idx      = addr[5:2];
        e.data   = '0;
        e.resp   = 2'b10;
        e.strobe = '0;
        if (idx < 4'd12) begin
            e.data = regs[idx];
            e.resp = 2'b00;
            if (COR[idx]) e.strobe = 12'b1 << idx;
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present an address and wait (bounded) for the AR handshake; pushes the expected response.
    task automatic applyStimulus(input logic [AW-1:0] addr, output bit ok);
        ok      = 1'b0;
        araddr  = addr;
        arvalid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (arready === 1'b1) begin
                sb.push_back(expectFor(addr));
                @(posedge clk); #1;
                arvalid = 1'b0;
                ok      = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        if (!ok) checkOutput("ar_handshake_timeout", 64'd0, 64'd1);
    endtask

    // Full read: handshake, check first rvalid cycle, hold off rready, then complete.
    task automatic doRead(input string tag, input logic [AW-1:0] addr, input int holdCycles,
                          input int mutIdx, input logic [DW-1:0] mutVal);
        bit   ok;
        exp_t e;
        applyStimulus(addr, ok);
        if (!ok) return;
        e = sb.pop_front();
        checkOutput({tag, "_rvalid_rise"}, 64'(rvalid), 64'd1);
        checkOutput({tag, "_arready_low"}, 64'(arready), 64'd0);
        checkOutput({tag, "_rdata"}, 64'(rdata), 64'(e.data));
        checkOutput({tag, "_rresp"}, 64'(rresp), 64'(e.resp));
        checkOutput({tag, "_strobe"}, 64'(rdStrobe), 64'(e.strobe));
        for (int h = 0; h < holdCycles; h++) begin
            if (h == 0 && mutIdx >= 0) regs[mutIdx] = mutVal;
            @(posedge clk); #1;
            checkOutput({tag, "_hold_rvalid"}, 64'(rvalid), 64'd1);
            checkOutput({tag, "_hold_arready"}, 64'(arready), 64'd0);
            checkOutput({tag, "_hold_rdata"}, 64'(rdata), 64'(e.data));
            checkOutput({tag, "_hold_strobe"}, 64'(rdStrobe), 64'd0);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        checkOutput({tag, "_rvalid_drop"}, 64'(rvalid), 64'd0);
        checkOutput({tag, "_arready_back"}, 64'(arready), 64'd1);
        checkOutput({tag, "_strobe_gone"}, 64'(rdStrobe), 64'd0);
    endtask

    initial begin
        logic [AW-1:0] b2bAddr [3];
        int            hs;
        bit            ok;
        exp_t          e;

        for (int i = 0; i < NREGS; i++) regs[i] = 32'hA000_0000 + 32'(i) * 32'h0000_0111;
        regs[3] = 32'hDEAD_BEEF;
        resetN  = 1'b0;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_arready", 64'(arready), 64'd0);
        checkOutput("reset_rvalid", 64'(rvalid), 64'd0);
        checkOutput("reset_rdata", 64'(rdata), 64'd0);
        checkOutput("reset_rresp", 64'(rresp), 64'd0);
        checkOutput("reset_strobe", 64'(rdStrobe), 64'd0);
        resetN = 1'b1;
        checkOutput("release_arready_low", 64'(arready), 64'd0);
        @(posedge clk); #1;
        checkOutput("release_arready_high", 64'(arready), 64'd1);

        // Single read of register 3, then backpressure while register 3 changes
        doRead("rd3", 6'h0C, 5, 3, 32'h0000_1234);
        // The new value is visible to the next read
        doRead("rd3_new", 6'h0C, 0, -1, '0);
        checkOutput("rd3_new_value", 64'(rdata), 64'h1234);

        // Out of range indices
        doRead("oor12", 6'h30, 1, -1, '0);
        doRead("oor15", 6'h3C, 0, -1, '0);

        // Clear-on-read register 5 and a plain register 4
        doRead("cor5", 6'h14, 2, -1, '0);
        doRead("plain4", 6'h10, 0, -1, '0);
        doRead("first0", 6'h00, 0, -1, '0);
        doRead("last11", 6'h2C, 0, -1, '0);

        // Misaligned address aliases down to register 5
        doRead("alias17", 6'h17, 0, -1, '0);

        // Back-to-back with arvalid held and rready held
        b2bAddr[0] = 6'h04;
        b2bAddr[1] = 6'h09;
        b2bAddr[2] = 6'h2C;
        hs      = 0;
        araddr  = b2bAddr[0];
        arvalid = 1'b1;
        rready  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bit took;
            took = 1'b0;
            checkOutput("b2b_not_both", 64'(rvalid && arready), 64'd0);
            if (rvalid === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("b2b_unexpected_rvalid", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("b2b_rdata", 64'(rdata), 64'(e.data));
                    checkOutput("b2b_rresp", 64'(rresp), 64'(e.resp));
                    checkOutput("b2b_strobe", 64'(rdStrobe), 64'(e.strobe));
                end
            end
            if (arready === 1'b1) begin
                sb.push_back(expectFor(araddr));
                hs++;
                took = 1'b1;
            end
            @(posedge clk); #1;
            if (took && hs < 3) araddr = b2bAddr[hs];
        end
        arvalid = 1'b0;
        checkOutput("b2b_handshakes", 64'(hs), 64'd3);
        checkOutput("b2b_sb_empty", 64'(sb.size()), 64'd0);
        checkOutput("b2b_rvalid_done", 64'(rvalid), 64'd0);
        rready = 1'b0;
        sb.delete();

        // Reset while a clear-on-read response is pending
        applyStimulus(6'h14, ok);
        checkOutput("midrst_rvalid_before", 64'(rvalid), 64'd1);
        checkOutput("midrst_strobe_before", 64'(rdStrobe), 64'h020);
        resetN = 1'b0;
        #1;
        checkOutput("midrst_rvalid", 64'(rvalid), 64'd0);
        checkOutput("midrst_arready", 64'(arready), 64'd0);
        checkOutput("midrst_strobe", 64'(rdStrobe), 64'd0);
        sb.delete();
        #2;
        resetN = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_arready_back", 64'(arready), 64'd1);
        checkOutput("midrst_rvalid_idle", 64'(rvalid), 64'd0);
        regs[7] = 32'hCAFE_F00D;
        doRead("after_rst", 6'h1C, 1, -1, '0);
        checkOutput("after_rst_value", 64'(rdata), 64'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule : tb_axi_lite_reg_read_slave
